// File: rtl/burst_reg_slave.sv
// burst_reg_slave
// Register-file slave with a valid/ready command phase. It serves single and
// burst reads and writes over NREGS registers. Bursts use either incrementing
// or aligned-wrapping addressing. Illegal commands are rejected with an err
// pulse.

module burst_reg_slave #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          valid,
  output logic          ready,
  input  logic [AW-1:0] address,
  input  logic          wr,
  input  logic          rd,
  input  logic [LW-1:0] length,
  input  logic          wrap,
  input  logic [DW-1:0] wdata,
  input  logic          wvalid,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          busy,
  output logic          err
);

  localparam int NREGS = 1 << AW;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]    state;
  logic [DW-1:0] regs [NREGS];
  logic [AW-1:0] addr_q;
  logic [AW-1:0] mask_q;
  logic [LW-1:0] rem_q;
  logic          dir_wr_q;
  logic          wrap_q;

  logic          len_pow2;
  logic          cmd_legal;
  logic          accept;
  logic          beat;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] addr_next;

  // Decode command legality, the accept/beat strobes and the next beat address
  always_comb begin
    len_pow2  = (length & (length - 1'b1)) == '0;
    cmd_legal = (wr ^ rd) && (length != '0) &&
                (!wrap || (len_pow2 && (int'(length) <= NREGS)));
    accept    = (state == IDLE) && valid && cmd_legal;
    beat      = (state == BURST) && (!dir_wr_q || wvalid);
    addr_inc  = addr_q + 1'b1;
    addr_next = addr_inc;
    if (wrap_q) begin
      addr_next = (addr_q & ~mask_q) | (addr_inc & mask_q);
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == BURST);

  // Command FSM: latch the burst on accept and step it one beat at a time
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      addr_q   <= '0;
      mask_q   <= '0;
      rem_q    <= '0;
      dir_wr_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (accept) begin
      state    <= BURST;
      addr_q   <= address;
      mask_q   <= AW'(length - 1'b1);
      rem_q    <= length;
      dir_wr_q <= wr;
      wrap_q   <= wrap;
    end else if (beat) begin
      addr_q <= addr_next;
      rem_q  <= rem_q - 1'b1;
      if (rem_q == LW'(1)) begin
        state <= IDLE;
      end
    end
  end

  // Register file: cleared on reset, written on completed write beats
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (beat && dir_wr_q) begin
      regs[addr_q] <= wdata;
    end
  end

  // Read data path: rvalid pulses per read beat, rdata holds between beats
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      if (beat && !dir_wr_q) begin
        rdata  <= regs[addr_q];
        rvalid <= 1'b1;
      end
    end
  end

  // Reject pulse for an illegal command offered while idle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else begin
      err <= (state == IDLE) && valid && !cmd_legal;
    end
  end

endmodule

// File: tb/tb_burst_reg_slave.sv
// tb_burst_reg_slave
// Directed bench for burst_reg_slave. Read tasks push hand-computed data into
// a scoreboard queue, and a negedge monitor pops the queue on every rvalid.

module tb_burst_reg_slave;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          valid = 1'b0;
  logic          ready;
  logic [AW-1:0] address = '0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [LW-1:0] length = '0;
  logic          wrap = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          wvalid = 1'b0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          busy;
  logic          err;

  int checks = 0;
  int failures = 0;
  int err_exp = 0;
  int err_seen = 0;

  logic [DW-1:0] sb [$];
  logic [DW-1:0] vals [$];
  logic [DW-1:0] mon_exp;

  burst_reg_slave #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .valid   (valid),
    .ready   (ready),
    .address (address),
    .wr      (wr),
    .rd      (rd),
    .length  (length),
    .wrap    (wrap),
    .wdata   (wdata),
    .wvalid  (wvalid),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: count err pulses and score every read beat against the queue
  always @(negedge clk) begin
    if (err) err_seen++;
    if (rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_rvalid actual=%0h expected=none at %0t", rdata, $time);
      end else begin
        mon_exp = sb.pop_front();
        check_output("rdata", 32'(rdata), 32'(mon_exp));
      end
    end
  end

  task automatic issue_cmd(input logic w, input logic r, input logic [AW-1:0] a,
                           input logic [LW-1:0] l, input logic wp);
    int n;
    n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) check_output("ready_timeout", 32'(ready), 32'd1);
    valid = 1'b1; wr = w; rd = r; address = a; length = l; wrap = wp;
    @(posedge clk); #1;
    valid = 1'b0; wr = 1'b0; rd = 1'b0; wrap = 1'b0; length = '0;
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic wp);
    int n;
    foreach (vals[i]) sb.push_back(vals[i]);
    issue_cmd(1'b0, 1'b1, a, l, wp);
    check_output("read_busy_start", 32'(busy), 32'd1);
    check_output("read_rvalid_early", 32'(rvalid), 32'd0);
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check_output("read_first_rvalid", 32'(rvalid), 32'd1);
    end
    check_output("read_busy_cycles", 32'(n), 32'(l));
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic wp,
                             input int stall, input int exp_cycles);
    int c;
    int i;
    issue_cmd(1'b1, 1'b0, a, l, wp);
    c = 0;
    i = 0;
    while (i < int'(l) && c < 40) begin
      if (c == stall) begin
        wvalid = 1'b0;
      end else begin
        wvalid = 1'b1;
        wdata  = vals[i];
      end
      @(posedge clk); #1;
      if (c != stall) i++;
      c++;
    end
    wvalid = 1'b0;
    check_output("write_done_idle", 32'(busy), 32'd0);
    check_output("write_cycles", 32'(c), 32'(exp_cycles));
  endtask

  task automatic illegal_cmd(input string name, input logic w, input logic r,
                             input logic [AW-1:0] a, input logic [LW-1:0] l, input logic wp);
    issue_cmd(w, r, a, l, wp);
    err_exp++;
    check_output({name, "_err"}, 32'(err), 32'd1);
    check_output({name, "_ready"}, 32'(ready), 32'd1);
    check_output({name, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check_output({name, "_err_clear"}, 32'(err), 32'd0);
  endtask

  // Watchdog so a stuck DUT still ends the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_ready", 32'(ready), 32'd1);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_rvalid", 32'(rvalid), 32'd0);
    check_output("reset_err", 32'(err), 32'd0);
    check_output("reset_rdata", 32'(rdata), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // single write then single read of reg2
    vals = '{8'hA5};
    write_burst(3'd2, 4'd1, 1'b0, -1, 1);
    read_burst(3'd2, 4'd1, 1'b0);

    // incrementing write crossing the top of the file: reg6, reg7, reg0, reg1
    vals = '{8'h01, 8'h02, 8'h03, 8'h04};
    write_burst(3'd6, 4'd4, 1'b0, -1, 4);
    read_burst(3'd6, 4'd4, 1'b0);
    vals = '{8'h03, 8'h04};
    read_burst(3'd0, 4'd2, 1'b0);

    // fill reg4..reg7, then wrapping read from reg5 in the aligned block 4..7
    vals = '{8'h40, 8'h41, 8'h42, 8'h43};
    write_burst(3'd4, 4'd4, 1'b0, -1, 4);
    vals = '{8'h41, 8'h42, 8'h43, 8'h40};
    read_burst(3'd5, 4'd4, 1'b1);

    // length 3 write with a one-cycle wvalid stall on the second cycle
    vals = '{8'h11, 8'h22, 8'h33};
    write_burst(3'd1, 4'd3, 1'b0, 1, 4);
    vals = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h40, 8'h41, 8'h42, 8'h43};
    read_burst(3'd0, 4'd8, 1'b0);

    // wrapping write from reg3 in block 2..3: reg3 then reg2
    vals = '{8'h77, 8'h66};
    write_burst(3'd3, 4'd2, 1'b1, -1, 2);
    vals = '{8'h66, 8'h77};
    read_burst(3'd2, 4'd2, 1'b0);

    // illegal commands
    illegal_cmd("ill_wr_rd", 1'b1, 1'b1, 3'd0, 4'd1, 1'b0);
    illegal_cmd("ill_none", 1'b0, 1'b0, 3'd0, 4'd1, 1'b0);
    illegal_cmd("ill_len0", 1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    illegal_cmd("ill_wrap3", 1'b1, 1'b0, 3'd1, 4'd3, 1'b1);
    illegal_cmd("ill_wrap15", 1'b0, 1'b1, 3'd1, 4'd15, 1'b1);
    vals = '{8'h03, 8'h11, 8'h66, 8'h77, 8'h40, 8'h41, 8'h42, 8'h43};
    read_burst(3'd0, 4'd8, 1'b0);

    // wrapping boundaries: length 1 stays put, length NREGS covers the file
    vals = '{8'h77};
    read_burst(3'd3, 4'd1, 1'b1);
    vals = '{8'h42, 8'h43, 8'h03, 8'h11, 8'h66, 8'h77, 8'h40, 8'h41};
    read_burst(3'd6, 4'd8, 1'b1);

    // reset in the middle of a length 7 read after two beats have been seen
    sb.push_back(8'h03);
    sb.push_back(8'h11);
    issue_cmd(1'b0, 1'b1, 3'd0, 4'd7, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    resetn = 1'b0;
    #1;
    check_output("midreset_rvalid", 32'(rvalid), 32'd0);
    check_output("midreset_busy", 32'(busy), 32'd0);
    check_output("midreset_ready", 32'(ready), 32'd1);
    check_output("midreset_rdata", 32'(rdata), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    vals = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    read_burst(3'd0, 4'd8, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
    check_output("err_pulse_count", 32'(err_seen), 32'(err_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
